// File: rtl/qpsk_demod.sv
// qpsk_demod: correlating QPSK demodulator, 20 samples per symbol.
// Decides one dibit per symbol and re-serialises it on Dout/DCLKout.

module qpsk_demod #(
    parameter int SPS   = 20,
    parameter int MID   = 2048,
    parameter int ACC_W = 26
) (
    input  logic        SCLKin,
    input  logic        RSTnin,
    input  logic [11:0] Sin,
    input  logic        SymSync,
    output logic [1:0]  Dibit,
    output logic        DibitValid,
    output logic        Locked,
    output logic        Dout,
    output logic        DCLKout
);

    localparam logic [4:0] LAST = 5'(SPS - 1);

    function automatic logic signed [7:0] sin_c(input logic [4:0] n);
        case (n)
            5'd1:    return 8'sd39;
            5'd2:    return 8'sd75;
            5'd3:    return 8'sd103;
            5'd4:    return 8'sd121;
            5'd5:    return 8'sd127;
            5'd6:    return 8'sd121;
            5'd7:    return 8'sd103;
            5'd8:    return 8'sd75;
            5'd9:    return 8'sd39;
            5'd11:   return -8'sd39;
            5'd12:   return -8'sd75;
            5'd13:   return -8'sd103;
            5'd14:   return -8'sd121;
            5'd15:   return -8'sd127;
            5'd16:   return -8'sd121;
            5'd17:   return -8'sd103;
            5'd18:   return -8'sd75;
            5'd19:   return -8'sd39;
            default: return 8'sd0;
        endcase
    endfunction

    logic [4:0]              cnt_q, cnt_d, cnt_eff, cos_idx;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic                    synced_q, synced_d;
    logic                    locked_q, locked_d;
    logic [1:0]              dibit_q, dibit_d;
    logic                    dv_q, dv_d;
    logic [4:0]              ph_q, ph_d, ph_inc, bitp;
    logic                    act_q, act_d;
    logic                    dout_q, dout_d;
    logic                    dclk_q, dclk_d;

    logic signed [12:0]      sc;
    logic signed [7:0]       ci, cq;
    logic signed [20:0]      prod_i, prod_q;
    logic signed [ACC_W-1:0] ext_i, ext_q, sum_i, sum_q;
    logic [ACC_W-1:0]        abs_i, abs_q;
    logic [1:0]              dec;
    logic                    sym_end, abort;

    // SymSync forces the current sample to position 0.
    assign cnt_eff = SymSync ? 5'd0 : cnt_q;
    assign cos_idx = (cnt_eff >= 5'd15) ? cnt_eff - 5'd15
                                        : cnt_eff + 5'd5;

    assign sc     = $signed({1'b0, Sin}) - $signed(13'(MID));
    assign ci     = sin_c(cnt_eff);
    assign cq     = sin_c(cos_idx);
    assign prod_i = sc * ci;
    assign prod_q = sc * cq;
    assign ext_i  = $signed({{(ACC_W-21){prod_i[20]}}, prod_i});
    assign ext_q  = $signed({{(ACC_W-21){prod_q[20]}}, prod_q});
    assign sum_i  = acc_i_q + ext_i;
    assign sum_q  = acc_q_q + ext_q;
    assign abs_i  = sum_i[ACC_W-1] ? -sum_i : sum_i;
    assign abs_q  = sum_q[ACC_W-1] ? -sum_q : sum_q;

    assign sym_end = (cnt_eff == LAST);
    assign abort   = SymSync && (cnt_q != 5'd0);

    // Quadrant decision; ties go to the I axis.
    always_comb begin
        dec = 2'b00;
        if (abs_i >= abs_q)
            dec = sum_i[ACC_W-1] ? 2'b10 : 2'b00;
        else if (!sum_q[ACC_W-1] && sum_q != '0)
            dec = 2'b01;
        else
            dec = 2'b11;
    end

    // Counter, accumulators, lock and serialiser next state.
    always_comb begin
        cnt_d    = sym_end ? 5'd0 : cnt_eff + 5'd1;
        acc_i_d  = acc_i_q + ext_i;
        acc_q_d  = acc_q_q + ext_q;
        synced_d = synced_q | SymSync;
        dv_d     = sym_end && synced_q;
        locked_d = locked_q | dv_d;
        dibit_d  = dv_d ? dec : dibit_q;
        ph_inc   = (ph_q == 5'd19) ? 5'd0 : ph_q + 5'd1;
        bitp     = (ph_inc < 5'd10) ? ph_inc : ph_inc - 5'd10;
        ph_d     = ph_q;
        act_d    = act_q;
        dout_d   = dout_q;
        dclk_d   = dclk_q;

        if (cnt_eff == 5'd0) begin
            acc_i_d = ext_i;
            acc_q_d = ext_q;
        end else if (sym_end) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end

        if (dv_d) begin
            ph_d   = 5'd0;
            act_d  = 1'b1;
            dout_d = dec[1];
            dclk_d = 1'b0;
        end else if (abort) begin
            act_d  = 1'b0;
            dclk_d = 1'b0;
        end else if (act_q) begin
            ph_d   = ph_inc;
            dout_d = (ph_inc < 5'd10) ? dibit_q[1] : dibit_q[0];
            dclk_d = (bitp >= 5'd5);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge SCLKin or negedge RSTnin) begin
        if (!RSTnin) begin
            cnt_q    <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            synced_q <= 1'b0;
            locked_q <= 1'b0;
            dibit_q  <= '0;
            dv_q     <= 1'b0;
            ph_q     <= '0;
            act_q    <= 1'b0;
            dout_q   <= 1'b0;
            dclk_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            synced_q <= synced_d;
            locked_q <= locked_d;
            dibit_q  <= dibit_d;
            dv_q     <= dv_d;
            ph_q     <= ph_d;
            act_q    <= act_d;
            dout_q   <= dout_d;
            dclk_q   <= dclk_d;
        end
    end

    assign Dibit      = dibit_q;
    assign DibitValid = dv_q;
    assign Locked     = locked_q;
    assign Dout       = dout_q;
    assign DCLKout    = dclk_q;

endmodule

// File: tb/tb_qpsk_demod.sv
// tb_qpsk_demod: randomized bench with a symbol-level reference model.
// Expected outputs per cycle are planned from the stimulus before playback.

`timescale 1ns/1ps

module tb_qpsk_demod;

    localparam int  MAXN = 400;
    localparam real PI   = 3.14159265358979;

    logic        SCLKin = 1'b0;
    logic        RSTnin = 1'b1;
    logic [11:0] Sin = 12'd2048;
    logic        SymSync = 1'b0;
    logic [1:0]  Dibit;
    logic        DibitValid, Locked, Dout, DCLKout;

    int checks = 0;
    int failures = 0;

    logic [11:0] p_sin [MAXN];
    bit          p_sync[MAXN];
    logic [5:0]  p_exp [MAXN+1];
    int          coef_s[20];
    int          coef_c[20];
    int          sym_buf[20];
    logic [5:0]  got;

    qpsk_demod dut (
        .SCLKin(SCLKin), .RSTnin(RSTnin), .Sin(Sin), .SymSync(SymSync),
        .Dibit(Dibit), .DibitValid(DibitValid), .Locked(Locked),
        .Dout(Dout), .DCLKout(DCLKout)
    );

    always #5 SCLKin = ~SCLKin;

    function automatic void init_coef();
        for (int n = 0; n < 20; n++) begin
            coef_s[n] = int'(127.0 * $sin(2.0 * PI * n / 20.0));
            coef_c[n] = int'(127.0 * $cos(2.0 * PI * n / 20.0));
        end
    endfunction

    function automatic logic [11:0] samp(int n, int k, int a, bit nz);
        real v;
        int  x;
        v = 2048.0 + a * $sin(2.0 * PI * (n + 5 * k) / 20.0);
        x = int'(v);
        if (nz) x = x + int'($urandom_range(16)) - 8;
        if (x < 0) x = 0;
        if (x > 4095) x = 4095;
        return 12'(x);
    endfunction

    function automatic logic [1:0] decide();
        longint i = 0, q = 0, ai, aq;
        for (int n = 0; n < 20; n++) begin
            i += longint'(sym_buf[n] - 2048) * coef_s[n];
            q += longint'(sym_buf[n] - 2048) * coef_c[n];
        end
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai >= aq) return (i >= 0) ? 2'b00 : 2'b10;
        return (q > 0) ? 2'b01 : 2'b11;
    endfunction

    function automatic void clear_plan(int n);
        for (int c = 0; c < n; c++) begin
            p_sin[c]  = 12'd2048;
            p_sync[c] = 1'b0;
        end
    endfunction

    function automatic void fill_sym(int start, int k, int a, bit nz);
        for (int j = 0; j < 20; j++) p_sin[start + j] = samp(j, k, a, nz);
    endfunction

    // Plans {DibitValid,Dibit,Locked,Dout,DCLKout} for cycles 0..n.
    function automatic void build_model(int n);
        int pos = 0, ph = 0;
        bit synced = 0, act = 0, lock = 0, dout = 0, dclk = 0;
        bit dv, abort;
        logic [1:0] dib = 2'b00;
        p_exp[0] = '0;
        for (int c = 0; c < n; c++) begin
            dv = 0;
            abort = 0;
            if (p_sync[c]) begin
                abort = synced && (((pos + 1) % 20) != 0);
                pos = 0;
                synced = 1;
            end else begin
                pos = (pos + 1) % 20;
            end
            sym_buf[pos] = int'(p_sin[c]);
            if (synced && pos == 19) begin
                dv = 1;
                dib = decide();
                lock = 1;
            end
            if (dv) begin
                act = 1; ph = 0; dout = dib[1]; dclk = 0;
            end else if (abort) begin
                act = 0; dclk = 0;
            end else if (act) begin
                ph = (ph + 1) % 20;
                dout = (ph < 10) ? dib[1] : dib[0];
                dclk = (ph % 10) >= 5;
            end
            p_exp[c+1] = {dv, dib, lock, dout, dclk};
        end
    endfunction

    task automatic apply_reset();
        RSTnin = 1'b0;
        SymSync = 1'b0;
        Sin = 12'd2048;
        @(posedge SCLKin);
        @(posedge SCLKin);
        #1 RSTnin = 1'b1;
    endtask

    task automatic drive(input int c, input int n);
        Sin = (c < n) ? p_sin[c] : 12'd2048;
        SymSync = (c < n) ? p_sync[c] : 1'b0;
    endtask

    task automatic test_reset();
        #2 RSTnin = 1'b0;
        #1;
        got = {DibitValid, Dibit, Locked, Dout, DCLKout};
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=000000", got);
        end
        apply_reset();
        #1;
        got = {DibitValid, Dibit, Locked, Dout, DCLKout};
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=000000", got);
        end
    endtask

    task automatic test_first_symbol();
        int n = 25;
        apply_reset();
        clear_plan(n);
        p_sync[0] = 1'b1;
        fill_sym(0, 0, 2047, 0);
        build_model(n);
        for (int c = 0; c <= n; c++) begin
            drive(c, n);
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== p_exp[c]) begin
                failures++;
                $display("FAIL first_sym c=%0d got=%b exp=%b", c, got, p_exp[c]);
            end
            if (c == 19 || c == 20) begin
                checks++;
                if (Locked !== (c == 20) || DibitValid !== (c == 20)
                    || Dibit !== 2'b00) begin
                    failures++;
                    $display("FAIL first_sym_spec c=%0d lock=%b dv=%b dib=%b",
                             c, Locked, DibitValid, Dibit);
                end
            end
            @(posedge SCLKin);
            #1;
        end
    endtask

    task automatic test_midscale();
        int n = 62;
        apply_reset();
        clear_plan(n);
        p_sync[0] = 1'b1;
        build_model(n);
        for (int c = 0; c <= n; c++) begin
            drive(c, n);
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== p_exp[c]) begin
                failures++;
                $display("FAIL midscale c=%0d got=%b exp=%b", c, got, p_exp[c]);
            end
            if (c == 20 || c == 40 || c == 60) begin
                checks++;
                if (DibitValid !== 1'b1 || Dibit !== 2'b00) begin
                    failures++;
                    $display("FAIL midscale_tie c=%0d dv=%b dib=%b exp dv=1 dib=00",
                             c, DibitValid, Dibit);
                end
            end
            @(posedge SCLKin);
            #1;
        end
    endtask

    task automatic test_continuous();
        int nsym = 12;
        int n = 20 * 12 + 25;
        int ks[12];
        bit bits[$];
        bit prev = 0;
        apply_reset();
        ks[0] = 0; ks[1] = 1; ks[2] = 2; ks[3] = 3; ks[4] = 2; ks[5] = 1;
        for (int s = 6; s < nsym; s++) ks[s] = int'($urandom_range(3));
        clear_plan(n);
        p_sync[0] = 1'b1;
        for (int s = 0; s < nsym; s++)
            fill_sym(20 * s, ks[s], int'($urandom_range(600, 2047)), 1);
        build_model(n);
        for (int c = 0; c <= n; c++) begin
            drive(c, n);
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== p_exp[c]) begin
                failures++;
                $display("FAIL continuous c=%0d got=%b exp=%b", c, got, p_exp[c]);
            end
            if (DCLKout === 1'b1 && !prev) bits.push_back(Dout);
            prev = (DCLKout === 1'b1);
            @(posedge SCLKin);
            #1;
        end
        checks++;
        if (bits.size() < 2 * nsym) begin
            failures++;
            $display("FAIL remod_count got=%0d exp>=%0d", bits.size(), 2 * nsym);
        end else begin
            for (int s = 0; s < nsym; s++) begin
                checks++;
                if ({bits[2*s], bits[2*s+1]} !== 2'(ks[s])) begin
                    failures++;
                    $display("FAIL remod sym=%0d got=%b%b exp=%b",
                             s, bits[2*s], bits[2*s+1], 2'(ks[s]));
                end
            end
        end
    endtask

    task automatic test_serial_timing();
        int n = 45;
        apply_reset();
        clear_plan(n);
        p_sync[0] = 1'b1;
        fill_sym(0, 2, 2047, 0);
        fill_sym(20, 2, 2047, 0);
        build_model(n);
        for (int c = 0; c <= n; c++) begin
            drive(c, n);
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== p_exp[c]) begin
                failures++;
                $display("FAIL serial c=%0d got=%b exp=%b", c, got, p_exp[c]);
            end
            if (c >= 20 && c <= 39) begin
                checks++;
                if (Dout !== (c < 30)
                    || DCLKout !== ((c >= 25 && c < 30) || c >= 35)) begin
                    failures++;
                    $display("FAIL serial_spec c=%0d dout=%b dclk=%b", c, Dout, DCLKout);
                end
            end
            @(posedge SCLKin);
            #1;
        end
    endtask

    task automatic test_realign();
        int n = 47 + 60 + 5;
        int hi = 0;
        apply_reset();
        clear_plan(n);
        p_sync[0] = 1'b1;
        fill_sym(0, int'($urandom_range(3)), 1500, 1);
        fill_sym(20, int'($urandom_range(3)), 1500, 1);
        fill_sym(40, int'($urandom_range(3)), 1500, 1);
        p_sync[47] = 1'b1;
        for (int s = 0; s < 3; s++)
            fill_sym(47 + 20 * s, int'($urandom_range(3)), 1500, 1);
        build_model(n);
        for (int c = 0; c <= n; c++) begin
            drive(c, n);
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== p_exp[c]) begin
                failures++;
                $display("FAIL realign c=%0d got=%b exp=%b", c, got, p_exp[c]);
            end
            if (c >= 48 && c <= 66 && DCLKout !== 1'b0) hi++;
            if (c == 60 || c == 67) begin
                checks++;
                if (DibitValid !== (c == 67)) begin
                    failures++;
                    $display("FAIL realign_dv c=%0d got=%b exp=%b",
                             c, DibitValid, (c == 67));
                end
            end
            @(posedge SCLKin);
            #1;
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL realign_dclk high_cycles=%0d exp=0", hi);
        end
    endtask

    task automatic test_reset_midsymbol();
        int n = 70;
        apply_reset();
        clear_plan(n);
        p_sync[0] = 1'b1;
        for (int s = 0; s < 3; s++)
            fill_sym(20 * s, int'($urandom_range(3)), 1800, 1);
        build_model(n);
        for (int c = 0; c <= 52; c++) begin
            drive(c, n);
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== p_exp[c]) begin
                failures++;
                $display("FAIL rst_mid_pre c=%0d got=%b exp=%b", c, got, p_exp[c]);
            end
            if (c == 52) break;
            @(posedge SCLKin);
            #1;
        end
        #2 RSTnin = 1'b0;
        #1;
        got = {DibitValid, Dibit, Locked, Dout, DCLKout};
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("FAIL rst_mid_async got=%b exp=000000", got);
        end
        @(posedge SCLKin);
        #1 RSTnin = 1'b1;
        for (int c = 0; c < 70; c++) begin
            Sin = 12'($urandom_range(4095));
            SymSync = 1'b0;
            got = {DibitValid, Dibit, Locked, Dout, DCLKout};
            checks++;
            if (got !== 6'b0) begin
                failures++;
                $display("FAIL rst_mid_idle c=%0d got=%b exp=000000", c, got);
            end
            @(posedge SCLKin);
            #1;
        end
    endtask

    initial begin
        init_coef();
        test_reset();
        test_first_symbol();
        test_midscale();
        test_continuous();
        test_serial_timing();
        test_realign();
        test_reset_midsymbol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
